// File: rtl/led_blinker_pkg.sv
// rtl/led_blinker_pkg.sv - shared types for the event-driven LED blinker
// Contents:
//   state_e : blinker phase (IDLE / ON / GAP)
package led_blinker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_e;

endpackage : led_blinker_pkg

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - free-running phase timer with clear, enable and terminal-count flag
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clr_i : force count to zero (wins over en_i)
//   en_i  : advance count by one
//   tc_o  : count is all-ones (terminal count)
module blink_timer #(
   parameter int WIDTH = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // The owner clears on terminal count, so the increment never wraps on its own.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = &cnt_q;

endmodule : blink_timer

// File: rtl/led_blinker.sv
// rtl/led_blinker.sv - queues single-cycle events and plays each as one LED pulse plus gap
// Optional feature macro: LED_BLINKER_OVF_EN (adds sticky overflow output)
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, overrides event_in
//   event_in : single-cycle event pulse, synchronous to clk
//   led      : registered LED drive, high only in ON
//   busy     : state is not IDLE
//   pending  : accepted events not yet started (saturating)
//   overflow : sticky, an event was dropped at full pending (LED_BLINKER_OVF_EN only)
module led_blinker
   import led_blinker_pkg::*;
#(
   parameter int ON_CNTR_WIDTH  = 20,
   parameter int OFF_CNTR_WIDTH = 20,
   parameter int PEND_WIDTH     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  event_in,
   output logic                  led,
   output logic                  busy,
   output logic [PEND_WIDTH-1:0] pending
`ifdef LED_BLINKER_OVF_EN
   ,
   output logic                  overflow
`endif
);

   localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

   state_e                state_q, state_d;
   logic                  led_q, led_d;
   logic [PEND_WIDTH-1:0] pend_q, pend_d;

   logic start;
   logic take;
   logic drop;
   logic on_tc, on_clr, on_en;
   logic gap_tc, gap_clr, gap_en;

   assign start = event_in || (pend_q != '0);

   blink_timer #(.WIDTH(ON_CNTR_WIDTH)) u_on_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (on_clr),
      .en_i  (on_en),
      .tc_o  (on_tc)
   );

   blink_timer #(.WIDTH(OFF_CNTR_WIDTH)) u_gap_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (gap_clr),
      .en_i  (gap_en),
      .tc_o  (gap_tc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; take marks the cycle an event is consumed to begin a pulse
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ON;
               take    = 1'b1;
            end
         end
         ON: begin
            if (on_tc) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_tc) begin
               if (start) begin
                  state_d = ON;
                  take    = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      led_d   = (state_d == ON);
      // Each timer is held at zero outside its own phase, so entry always starts from 0.
      on_en   = (state_q == ON);
      on_clr  = (state_q != ON) || on_tc;
      gap_en  = (state_q == GAP);
      gap_clr = (state_q != GAP) || gap_tc;

      // A start uses the live event_in first; only otherwise does it draw on the queue.
      drop   = 1'b0;
      pend_d = pend_q;
      if (take) begin
         if (!event_in) begin
            pend_d = pend_q - PEND_WIDTH'(1);
         end
      end else if (event_in) begin
         if (pend_q == PEND_MAX) begin
            drop = 1'b1;
         end else begin
            pend_d = pend_q + PEND_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q  <= 1'b0;
         pend_q <= '0;
      end else begin
         led_q  <= led_d;
         pend_q <= pend_d;
      end
   end

`ifdef LED_BLINKER_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end
   end

   assign overflow = ovf_q;
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif

   assign led     = led_q;
   assign busy    = (state_q != IDLE);
   assign pending = pend_q;

endmodule : led_blinker

// File: tb/tb_led_blinker.sv
// tb/tb_led_blinker.sv - self-checking bench for led_blinker (ON=3, OFF=2, PEND=2)
module tb_led_blinker;

   localparam int ONW    = 3;
   localparam int OFFW   = 2;
   localparam int PW     = 2;
   localparam int ON_LEN = 8;
   localparam int GAP_LEN = 4;
   localparam int PMAX   = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          event_in = 1'b0;
   logic          led;
   logic          busy;
   logic [PW-1:0] pending;
`ifdef LED_BLINKER_OVF_EN
   logic          overflow;
`endif

   always #5 clk = ~clk;

   led_blinker #(
      .ON_CNTR_WIDTH  (ONW),
      .OFF_CNTR_WIDTH (OFFW),
      .PEND_WIDTH     (PW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .event_in (event_in),
      .led      (led),
      .busy     (busy),
      .pending  (pending)
`ifdef LED_BLINKER_OVF_EN
      ,
      .overflow (overflow)
`endif
   );

   typedef struct {
      logic     led;
      logic     busy;
      int       pend;
      logic     ovf;
   } exp_t;

   exp_t sb[$];

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase 0 idle, 1 on, 2 gap; left = cycles remaining in phase
   int   m_phase = 0;
   int   m_left  = 0;
   int   m_pend  = 0;
   logic m_ovf   = 1'b0;

   int   pulses = 0;
   logic led_prev = 1'b0;

   task automatic model_edge(input logic ev, input logic rs);
      logic strt;
      logic took;
      took = 1'b0;
      if (rs) begin
         m_phase = 0; m_left = 0; m_pend = 0; m_ovf = 1'b0;
      end else begin
         strt = ev || (m_pend != 0);
         case (m_phase)
            0: if (strt) begin m_phase = 1; m_left = ON_LEN; took = 1'b1; end
            1: if (m_left == 1) begin m_phase = 2; m_left = GAP_LEN; end
               else m_left--;
            default: begin
               if (m_left == 1) begin
                  if (strt) begin m_phase = 1; m_left = ON_LEN; took = 1'b1; end
                  else m_phase = 0;
               end else m_left--;
            end
         endcase
         if (took) begin
            if (!ev) m_pend--;
         end else if (ev) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else m_pend++;
         end
      end
   endtask

   // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
   task automatic step(input logic ev, input logic rs);
      exp_t e;
      event_in = ev;
      rst      = rs;
      model_edge(ev, rs);
      e.led  = (m_phase == 1);
      e.busy = (m_phase != 0);
      e.pend = m_pend;
      e.ovf  = m_ovf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (led !== e.led) begin
         miscompares++;
         $display("FAIL led: got %b expected %b at %0t", led, e.led, $time);
      end
      vectors++;
      if (busy !== e.busy) begin
         miscompares++;
         $display("FAIL busy: got %b expected %b at %0t", busy, e.busy, $time);
      end
      vectors++;
      if (pending !== PW'(e.pend)) begin
         miscompares++;
         $display("FAIL pending: got %0d expected %0d at %0t", pending, e.pend, $time);
      end
`ifdef LED_BLINKER_OVF_EN
      vectors++;
      if (overflow !== e.ovf) begin
         miscompares++;
         $display("FAIL overflow: got %b expected %b at %0t", overflow, e.ovf, $time);
      end
`endif
      if (led === 1'b1 && led_prev !== 1'b1) pulses++;
      led_prev = led;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      pulses = 0;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic check_pulses(input string name, input int want);
      vectors++;
      if (pulses != want) begin
         miscompares++;
         $display("FAIL %s pulses: got %0d expected %0d", name, pulses, want);
      end
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      pulses = 0;
      vectors++;
      if (led !== 1'b0 || busy !== 1'b0 || pending !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got led=%b busy=%b pend=%0d expected 0/0/0", led, busy, pending);
      end
      idle_steps(5);
      check_pulses("reset_event_discard", 0);
   endtask

   task automatic test_single();
      logic [13:0] obs_led;
      logic [13:0] obs_busy;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(i == 0, 1'b0);
         obs_led[i]  = led;
         obs_busy[i] = busy;
      end
      vectors++;
      if (obs_led !== 14'h00FF) begin
         miscompares++;
         $display("FAIL single_led_pattern: got %h expected %h", obs_led, 14'h00FF);
      end
      vectors++;
      if (obs_busy !== 14'h0FFF) begin
         miscompares++;
         $display("FAIL single_busy_pattern: got %h expected %h", obs_busy, 14'h0FFF);
      end
      check_pulses("single", 1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      vectors++;
      if (pending !== PW'(1)) begin
         miscompares++;
         $display("FAIL b2b_pend1: got %0d expected 1", pending);
      end
      step(1'b1, 1'b0);
      vectors++;
      if (pending !== PW'(2)) begin
         miscompares++;
         $display("FAIL b2b_pend2: got %0d expected 2", pending);
      end
      idle_steps(40);
      check_pulses("back_to_back", 3);
   endtask

   task automatic test_gap_terminal();
      do_reset();
      for (int c = 0; c <= 12; c++) step((c == 0) || (c == 2) || (c == 12), 1'b0);
      vectors++;
      if (pending !== PW'(1) || led !== 1'b1) begin
         miscompares++;
         $display("FAIL gap_terminal: got pend=%0d led=%b expected pend=1 led=1", pending, led);
      end
      idle_steps(30);
      check_pulses("gap_terminal", 3);
   endtask

   task automatic test_saturate();
      do_reset();
      for (int c = 0; c <= 5; c++) step(1'b1, 1'b0);
      vectors++;
      if (pending !== PW'(3)) begin
         miscompares++;
         $display("FAIL saturate_pend: got %0d expected 3", pending);
      end
`ifdef LED_BLINKER_OVF_EN
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL saturate_ovf: got %b expected 1", overflow);
      end
`endif
      idle_steps(50);
      check_pulses("saturate", 4);
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      vectors++;
      if (led !== 1'b0 || pending !== '0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: got led=%b pend=%0d busy=%b expected 0/0/0", led, pending, busy);
      end
      pulses = 0;
      idle_steps(20);
      check_pulses("reset_mid_lost", 0);
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 5) == 0, $urandom_range(0, 99) == 0);
      end
      idle_steps(60);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gap_terminal();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_led_blinker
